// File: rtl/tile_mem_pkg.sv
// Shared definitions for the tile SRAM bank arbiter: bank geometry helpers,
// the per-requester in-flight tag and the SRAM region check.
package tile_mem_pkg;

    function automatic int bank_bits(input int num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic int offset_bits(input int addr_bits, input int num_banks);
        return addr_bits - $clog2(num_banks);
    endfunction

    localparam int DEF_NUM_REQ   = 32'sd4;
    localparam int DEF_ADDR_BITS = 32'sd8;
    localparam int DEF_NUM_BANKS = 32'sd8;
    localparam int DEF_DATA_BITS = 32'sd8;
    localparam int DEF_CNT_BITS  = 32'sd16;

    localparam int TAG_BANK_BITS = bank_bits(DEF_NUM_BANKS);

    typedef struct packed {
        logic [TAG_BANK_BITS-1:0] bank;
        logic                     write;
        logic                     err;
    } tag_t;

    function automatic logic in_region(input logic [DEF_ADDR_BITS-1:0] addr,
                                       input logic [DEF_ADDR_BITS-1:0] base,
                                       input logic [DEF_ADDR_BITS-1:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/tile_rr_arbiter.sv
// Round-robin grant for one bank: the first requester at or after the pointer
// wins, and the pointer moves just past the winner whenever a grant is made.
module tile_rr_arbiter #(
    parameter int N = 32'sd4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic          found;
    logic          hit;
    int            idx;

    // Scan requesters starting at the pointer, wrapping, and keep the first hit.
    always_comb begin
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        hit      = 1'b0;
        idx      = 32'sd0;
        for (int k = 32'sd0; k < N; k++) begin
            idx        = (int'(ptr) + k) % N;
            hit        = req[idx] & ~found;
            grant[idx] = hit;
            found      = found | hit;
            ptr_next   = hit ? PW'((idx + 32'sd1) % N) : ptr_next;
        end
    end

    // Pointer register; an idle bank keeps its pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/tile_bank_arbiter.sv
// Tile SRAM bank arbiter: decodes requester addresses onto interleaved banks,
// arbitrates each bank round-robin and returns one-cycle responses.
module tile_bank_arbiter
    import tile_mem_pkg::*;
#(
    parameter  int NUM_REQ     = DEF_NUM_REQ,
    parameter  int ADDR_BITS   = DEF_ADDR_BITS,
    parameter  int NUM_BANKS   = DEF_NUM_BANKS,
    parameter  int DATA_BITS   = DEF_DATA_BITS,
    parameter  int CNT_BITS    = DEF_CNT_BITS,
    localparam int BANK_BITS   = bank_bits(NUM_BANKS),
    localparam int OFFSET_BITS = offset_bits(ADDR_BITS, NUM_BANKS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ADDR_BITS-1:0]             sram_base,
    input  logic [ADDR_BITS-1:0]             sram_limit,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_BITS-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_BITS-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_BANKS-1:0]             bank_en,
    output logic [NUM_BANKS-1:0]             bank_we,
    output logic [NUM_BANKS*OFFSET_BITS-1:0] bank_offset,
    output logic [NUM_BANKS*DATA_BITS-1:0]   bank_wdata,
    input  logic [NUM_BANKS*DATA_BITS-1:0]   bank_rdata,
    output logic [NUM_REQ-1:0]               resp_valid,
    output logic [NUM_REQ-1:0]               resp_err,
    output logic [NUM_REQ*DATA_BITS-1:0]     resp_rdata,
    output logic [CNT_BITS-1:0]              conflict_count
);

    localparam int SW = $clog2(NUM_REQ + 32'sd1);

    logic [NUM_REQ-1:0]   hit;
    logic [NUM_REQ-1:0]   miss;
    logic [NUM_REQ-1:0]   granted;
    logic [BANK_BITS-1:0] req_bank [NUM_REQ];
    logic [NUM_REQ-1:0]   bank_req [NUM_BANKS];
    logic [NUM_REQ-1:0]   bank_gnt [NUM_BANKS];
    tag_t                 tag      [NUM_REQ];
    logic [SW-1:0]        stall_cnt;
    logic [CNT_BITS:0]    cnt_sum;

    // Decode each request into bank and region; reset masks every request.
    always_comb begin
        hit  = '0;
        miss = '0;
        for (int i = 32'sd0; i < NUM_REQ; i++) begin
            req_bank[i] = req_addr[i*ADDR_BITS +: BANK_BITS];
            hit[i]  = ~reset & req_valid[i] &
                      in_region(req_addr[i*ADDR_BITS +: ADDR_BITS], sram_base, sram_limit);
            miss[i] = ~reset & req_valid[i] &
                      ~in_region(req_addr[i*ADDR_BITS +: ADDR_BITS], sram_base, sram_limit);
        end
        for (int b = 32'sd0; b < NUM_BANKS; b++) begin
            for (int i = 32'sd0; i < NUM_REQ; i++) begin
                bank_req[b][i] = hit[i] & (req_bank[i] == BANK_BITS'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        tile_rr_arbiter #(.N(NUM_REQ)) u_arb (
            .clk   (clk),
            .reset (reset),
            .req   (bank_req[b]),
            .grant (bank_gnt[b])
        );
    end

    // Steer the (one-hot) winner of each bank onto its strobes; count losers.
    always_comb begin
        granted     = '0;
        bank_en     = '0;
        bank_we     = '0;
        bank_offset = '0;
        bank_wdata  = '0;
        stall_cnt   = '0;
        for (int b = 32'sd0; b < NUM_BANKS; b++) begin
            bank_en[b] = |bank_gnt[b];
            for (int i = 32'sd0; i < NUM_REQ; i++) begin
                granted[i] = granted[i] | bank_gnt[b][i];
                bank_we[b] = bank_we[b] | (bank_gnt[b][i] & req_write[i]);
                bank_offset[b*OFFSET_BITS +: OFFSET_BITS] = bank_offset[b*OFFSET_BITS +: OFFSET_BITS] |
                    ({OFFSET_BITS{bank_gnt[b][i]}} & req_addr[i*ADDR_BITS+BANK_BITS +: OFFSET_BITS]);
                bank_wdata[b*DATA_BITS +: DATA_BITS] = bank_wdata[b*DATA_BITS +: DATA_BITS] |
                    ({DATA_BITS{bank_gnt[b][i]}} & req_wdata[i*DATA_BITS +: DATA_BITS]);
            end
        end
        for (int i = 32'sd0; i < NUM_REQ; i++) begin
            stall_cnt = stall_cnt + {{(SW-1){1'b0}}, hit[i] & ~granted[i]};
        end
        req_ready = granted | miss;
        cnt_sum   = {1'b0, conflict_count} + (CNT_BITS+1)'(stall_cnt);
    end

    // Response strobes, in-flight tags and the saturating conflict counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid     <= '0;
            resp_err       <= '0;
            conflict_count <= '0;
            for (int i = 32'sd0; i < NUM_REQ; i++) begin
                tag[i] <= '0;
            end
        end else begin
            resp_valid     <= req_ready;
            resp_err       <= miss;
            conflict_count <= cnt_sum[CNT_BITS] ? '1 : cnt_sum[CNT_BITS-1:0];
            for (int i = 32'sd0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    tag[i] <= '{bank: req_bank[i], write: req_write[i], err: miss[i]};
                end
            end
        end
    end

    // Bank read data arrives one cycle after the strobe, so it is steered here
    // by the registered tag rather than captured.
    always_comb begin
        resp_rdata = '0;
        for (int i = 32'sd0; i < NUM_REQ; i++) begin
            resp_rdata[i*DATA_BITS +: DATA_BITS] =
                (resp_valid[i] & ~tag[i].write & ~tag[i].err) ?
                bank_rdata[int'(tag[i].bank)*DATA_BITS +: DATA_BITS] : '0;
        end
    end

endmodule

// File: tb/tb_tile_bank_arbiter.sv
// Randomised scoreboard bench for tile_bank_arbiter with a flat-memory reference model.
module tb_tile_bank_arbiter;

    logic        clk;
    logic        reset;
    logic [7:0]  sram_base, sram_limit;
    logic [3:0]  req_valid, req_write, req_ready;
    logic [31:0] req_addr, req_wdata;
    logic [7:0]  bank_en, bank_we;
    logic [39:0] bank_offset;
    logic [63:0] bank_wdata, bank_rdata;
    logic [3:0]  resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [15:0] conflict_count;

    tile_bank_arbiter dut (
        .clk(clk), .reset(reset), .sram_base(sram_base), .sram_limit(sram_limit),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .bank_en(bank_en), .bank_we(bank_we), .bank_offset(bank_offset),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata), .resp_valid(resp_valid),
        .resp_err(resp_err), .resp_rdata(resp_rdata), .conflict_count(conflict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int due; logic err; logic [7:0] data; } exp_t;

    int          total, bad, cyc, exp_cnt;
    int          ptr [8];
    exp_t        sbq [4][$];
    logic [7:0]  refmem [int];
    logic [3:0]  rv, rw, dut_ready;
    logic [7:0]  ra [4];
    logic [7:0]  rd [4];
    logic [7:0]  base, limit;
    logic [7:0]  envmem [256];
    logic [7:0]  rdq [8];

    function automatic logic [7:0] init_val(input int a);
        return 8'((a * 7 + 3) & 255);
    endfunction

    function automatic logic [7:0] ref_rd(input int a);
        return refmem.exists(a) ? refmem[a] : init_val(a);
    endfunction

    function automatic logic in_reg(input logic [7:0] a);
        return (a >= base) && (a <= limit);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Banked SRAM environment, driven only by the DUT strobes.
    always @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < 256; a++) envmem[a] <= init_val(a);
            for (int b = 0; b < 8; b++) rdq[b] <= 8'h00;
        end else begin
            for (int b = 0; b < 8; b++) begin
                if (bank_en[b]) begin
                    if (bank_we[b]) envmem[int'(bank_offset[b*5 +: 5]) * 8 + b] <= bank_wdata[b*8 +: 8];
                    else rdq[b] <= envmem[int'(bank_offset[b*5 +: 5]) * 8 + b];
                end
            end
        end
    end

    always_comb begin
        bank_rdata = '0;
        for (int b = 0; b < 8; b++) bank_rdata[b*8 +: 8] = rdq[b];
    end

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // Monitor: a response must appear exactly on the cycle its entry is due.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            chk("resp_valid_in_reset", 64'(resp_valid), 64'd0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sbq[i].size() > 0 && sbq[i][0].due == cyc) begin
                    e = sbq[i].pop_front();
                    chk("resp_valid", 64'(resp_valid[i]), 64'd1);
                    chk("resp_err", 64'(resp_err[i]), 64'(e.err));
                    chk("resp_rdata", 64'(resp_rdata[i*8 +: 8]), 64'(e.data));
                end else begin
                    chk("resp_spurious", 64'(resp_valid[i]), 64'd0);
                end
            end
        end
    end

    task automatic model_reset();
        for (int b = 0; b < 8; b++) ptr[b] = 0;
        for (int i = 0; i < 4; i++) sbq[i].delete();
        refmem.delete();
        exp_cnt = 0;
        rv = 4'd0;
    endtask

    // Drive the current requests, predict the combinational outputs, then commit.
    task automatic drive_and_check();
        int         win [8];
        logic       hv [4];
        logic [3:0] er;
        logic [7:0] een, ewe;
        int         stall, j;
        exp_t       e;
        sram_base = base;
        sram_limit = limit;
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = rv[i];
            req_write[i] = rw[i];
            req_addr[i*8 +: 8] = ra[i];
            req_wdata[i*8 +: 8] = rd[i];
            hv[i] = rv[i] && in_reg(ra[i]);
        end
        er = 4'd0; een = 8'd0; ewe = 8'd0; stall = 0;
        for (int b = 0; b < 8; b++) begin
            win[b] = -1;
            for (int k = 0; k < 4; k++) begin
                j = (ptr[b] + k) % 4;
                if (win[b] < 0 && hv[j] && int'(ra[j] % 8) == b) win[b] = j;
            end
            if (win[b] >= 0) begin
                een[b] = 1'b1;
                ewe[b] = rw[win[b]];
                er[win[b]] = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (rv[i] && !hv[i]) er[i] = 1'b1;
            else if (hv[i] && !er[i]) stall++;
        end
        #1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("bank_en", 64'(bank_en), 64'(een));
        chk("bank_we", 64'(bank_we), 64'(ewe));
        for (int b = 0; b < 8; b++) begin
            if (een[b]) begin
                chk("bank_offset", 64'(bank_offset[b*5 +: 5]), 64'(ra[win[b]] / 8));
                if (ewe[b]) chk("bank_wdata", 64'(bank_wdata[b*8 +: 8]), 64'(rd[win[b]]));
            end
        end
        dut_ready = req_ready;
        for (int i = 0; i < 4; i++) begin
            if (er[i]) begin
                e.due = cyc + 1;
                e.err = !hv[i];
                e.data = (e.err || rw[i]) ? 8'h00 : ref_rd(int'(ra[i]));
                sbq[i].push_back(e);
            end
        end
        for (int b = 0; b < 8; b++) begin
            if (win[b] >= 0) begin
                if (rw[win[b]]) refmem[int'(ra[win[b]])] = rd[win[b]];
                ptr[b] = (win[b] + 1) % 4;
            end
        end
        exp_cnt = (exp_cnt + stall > 65535) ? 65535 : exp_cnt + stall;
        rv = rv & ~er;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("conflict_count", 64'(conflict_count), 64'(exp_cnt));
        drive_and_check();
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1;
        base = 8'h00; limit = 8'hBF;
        rw = 4'd0;
        for (int i = 0; i < 4; i++) begin ra[i] = 8'h00; rd[i] = 8'h00; end
        req_valid = 4'd0; req_write = 4'd0; req_addr = 32'd0; req_wdata = 32'd0;
        sram_base = base; sram_limit = limit;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_bank_en", 64'(bank_en), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        chk("rst_conflict", 64'(conflict_count), 64'd0);

        // A read is accepted, its response is registered, then reset drops it.
        rv = 4'b0001; rw = 4'd0; ra[0] = 8'h10;
        step();
        chk("inflight_accept", 64'(dut_ready), 64'd1);
        step();
        chk("inflight_resp", 64'(resp_valid), 64'd1);
        #1 reset = 1'b1;
        model_reset();
        req_valid = 4'b0001;
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_bank_en", 64'(bank_en), 64'd0);
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        req_valid = 4'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("post_rst_resp", 64'(resp_valid), 64'd0);
        chk("post_rst_conflict", 64'(conflict_count), 64'd0);

        // Full conflict on bank 0.
        rv = 4'hF; rw = 4'd0;
        ra[0] = 8'h08; ra[1] = 8'h10; ra[2] = 8'h18; ra[3] = 8'h20;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("fc_grant", 64'(dut_ready), 64'(1 << k));
            chk("fc_offset", 64'(bank_offset[4:0]), 64'(k + 1));
        end
        rv = 4'd0;
        step();
        chk("fc_count", 64'(conflict_count), 64'd6);

        // Conflict-free reads to banks 0..3.
        rv = 4'hF;
        ra[0] = 8'h10; ra[1] = 8'h11; ra[2] = 8'h12; ra[3] = 8'h13;
        step();
        chk("cf_ready", 64'(req_ready), 64'hF);
        chk("cf_bank_en", 64'(bank_en), 64'h0F);
        chk("cf_offsets", 64'(bank_offset[19:0]), 64'h10842);
        step();
        chk("cf_resp_valid", 64'(resp_valid), 64'hF);
        step();
        chk("cf_count", 64'(conflict_count), 64'd6);

        // Fairness: requesters 0 and 2 hammer bank 3.
        ra[0] = 8'h03; ra[2] = 8'h0B;
        for (int k = 0; k < 6; k++) begin
            rv[0] = 1'b1; rv[2] = 1'b1;
            step();
            chk("fair_grant", 64'(dut_ready), (k % 2 == 0) ? 64'h1 : 64'h4);
        end
        rv = 4'd0;
        step();

        // Out-of-region below base and above limit.
        base = 8'h20;
        rv = 4'b0011; rw = 4'd0; ra[0] = 8'h10; ra[1] = 8'hC0;
        step();
        chk("err_ready", 64'(req_ready), 64'h3);
        chk("err_bank_en", 64'(bank_en), 64'h0);
        step();
        chk("err_flag", 64'(resp_err), 64'h3);
        chk("err_rdata", 64'(resp_rdata), 64'h0);
        base = 8'h00;

        // Write then read back through bank 3, offset 5.
        rv = 4'b0010; rw = 4'b0010; ra[1] = 8'h2B; rd[1] = 8'hA5;
        step();
        chk("wr_we", 64'(bank_we), 64'h08);
        chk("wr_offset", 64'(bank_offset[19:15]), 64'd5);
        rv = 4'b0010; rw = 4'd0;
        step();
        step();
        chk("rd_back", 64'(resp_rdata[15:8]), 64'hA5);

        // Randomised traffic with occasional withdrawals and region changes.
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                base = 8'($urandom_range(0, 64));
                limit = 8'($urandom_range(160, 255));
            end
            for (int i = 0; i < 4; i++) begin
                if (!rv[i]) begin
                    if ($urandom % 4 != 0) begin
                        rv[i] = 1'b1;
                        rw[i] = 1'($urandom % 2);
                        ra[i] = ($urandom % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3) * 8 + 3);
                        rd[i] = 8'($urandom);
                    end
                end else if ($urandom % 8 == 0) begin
                    rv[i] = 1'b0;
                end
            end
            step();
        end
        rv = 4'd0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tile_bank_arbiter.md
# tile_bank_arbiter

Schedules load/store requests from `NUM_REQ` requesters onto the `NUM_BANKS` interleaved tile SRAM banks. It sits between the core load/store units and the bank array. Each request address is decoded into a bank and an offset, and each bank gets a round-robin grant per cycle. The bank strobes are driven, one-cycle responses are returned, and out-of-region accesses are flagged with an error. A saturating conflict counter exposes bank-contention statistics for scalability studies.

## Interface
- `NUM_REQ`, 4, number of requesters.
- `ADDR_BITS`, 8, global address width.
- `NUM_BANKS`, 8, SRAM banks (power of two); `BANK_BITS = $clog2(NUM_BANKS)`, `OFFSET_BITS = ADDR_BITS - BANK_BITS`.
- `DATA_BITS`, 8, data width.
- `CNT_BITS`, 16, conflict counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `sram_base`, `sram_limit`  in  ADDR_BITS each  inclusive SRAM region bounds (quasi-static).
- `req_valid`, `req_write`  in  NUM_REQ each  request strobe and write flag, per requester.
- `req_addr`  in  NUM_REQ*ADDR_BITS  packed addresses, requester i at slice i.
- `req_wdata`  in  NUM_REQ*DATA_BITS  packed write data.
- `req_ready`  out  NUM_REQ  request accepted this cycle.
- `bank_en`, `bank_we`  out  NUM_BANKS each  bank access strobe and write enable.
- `bank_offset`  out  NUM_BANKS*OFFSET_BITS  row per bank.
- `bank_wdata`  out  NUM_BANKS*DATA_BITS  write data per bank.
- `bank_rdata`  in  NUM_BANKS*DATA_BITS  read data, valid one cycle after `bank_en`.
- `resp_valid`, `resp_err`  out  NUM_REQ each  response strobe and out-of-region flag.
- `resp_rdata`  out  NUM_REQ*DATA_BITS  read data; 0 for writes and errors.
- `conflict_count`  out  CNT_BITS  saturating count of bank-conflict stalls.

## Operation
- Decode per requester:
  - In-region is `base <= addr <= limit`.
  - `bank = addr[BANK_BITS-1:0]`, `offset = addr[ADDR_BITS-1:BANK_BITS]`.
- Out-of-region request:
  - `req_ready=1` the same cycle, and no bank is accessed.
  - Next cycle: `resp_valid=1`, `resp_err=1`, `resp_rdata=0`.
- Per-bank arbitration:
  - Each bank holds a round-robin pointer `ptr[b]` in 0..NUM_REQ-1.
  - Among valid in-region requesters targeting bank b, the grant goes to the first index at or after `ptr[b]`, wrapping.
  - A grant to requester i sets `ptr[b] = (i+1) mod NUM_REQ`; a bank with no grant keeps its pointer.
- Granted request drives the bank: `bank_en[b]=1`, `bank_we[b]=req_write[i]`, plus offset and wdata, with `req_ready[i]=1`.
- Each requester holds one in-flight tag (bank id, write, err) registered at acceptance.
- Response at the next cycle: `resp_valid[i]=1`, `resp_err=0`, and `resp_rdata = bank_rdata[bank]` for reads or 0 for writes.
- Requesters hold `valid`, `addr`, `write` and `wdata` stable until `ready`. Dropping `valid` before `ready` is legal and withdraws the request.
- Conflict counter: each cycle it adds the number of valid in-region requesters not granted, saturating at all-ones.
- A requester may issue back-to-back, one request per cycle. A new acceptance and the previous response can occur in the same cycle.
- Reset (asynchronous, at any time) clears all pointers, tags, `resp_*` and `conflict_count` to 0, and in-flight responses are dropped.
  - All combinational outputs (`req_ready`, `bank_*`) are 0 while `reset` is high.

## Timing
- Accept-to-response latency: exactly 1 cycle for both hits and errors.
- `req_ready` and `bank_*` are combinational from the `req_*` inputs, region bounds and pointer registers.
- `resp_*` and `conflict_count` are registered. There is no combinational path from `bank_rdata` to `req_ready`.
- A stalled requester waits at most NUM_REQ-1 cycles for its bank.

## Structure
- Shared package `tile_mem_pkg` holds:
  - `BANK_BITS`/`OFFSET_BITS` helper functions;
  - the in-flight tag typedef `{bank, write, err}`;
  - the region-check function.
- Sub-module `tile_rr_arbiter`: NUM_REQ-wide round-robin grant with pointer register and advance-on-grant, instantiated once per bank.

## Test plan
All scenarios use base=0x00 and limit=0xBF unless stated.
- Reset: assert `reset` mid-stream with a read in flight -> no `resp_valid` follows. After release, all outputs are 0, `conflict_count=0` and pointers are 0.
- Conflict-free: requesters 0–3 read 0x10, 0x11, 0x12, 0x13 -> `req_ready=4'hF` and `bank_en=8'h0F` with offset 2 each. Next cycle all `resp_valid` are set with matching `bank_rdata`, and `conflict_count` stays 0.
- Full conflict: all four hold reads to 0x08, 0x10, 0x18, 0x20 (bank 0) -> grants go to 0, 1, 2, 3 on consecutive cycles with offsets 1, 2, 3, 4, and `conflict_count=6`.
- Fairness: requesters 0 and 2 continuously target bank 3 -> grants alternate 0, 2, 0, 2, and neither waits more than 1 cycle.
- Errors: with base=0x20, reads to 0x10 and 0xC0 -> `req_ready` the same cycle and `bank_en=0`. Next cycle `resp_err=1` and `resp_rdata=0`.
- Write then read: requester 1 writes 0xA5 to 0x2B, then reads 0x2B -> `bank_we[3]=1` at offset 5, followed by a read response of 0xA5.
